cache_controller: RTL

//  Control FSM that sits between the CPU data port, the 128-bit/32-line direct-mapped cache data array and 32-bit main memory.

---
 rtl/cache_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//   Control FSM between the CPU data port, a 32-line direct-mapped cache of
//   128-bit lines and a 32-bit main memory.
//   - Read hits are served in the request cycle (cache_re, no stall).
//   - Read misses fetch the 4-word line from memory, then pulse refill. The
//     following cycle sees hit=1 and completes the read.
//   - Writes are write-through and no-write-allocate. The word always goes to
//     memory. The cache word is updated only on a hit, in the cycle memory
//     accepts the write.
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   cpu_re/cpu_we           CPU request levels, held while stall=1
//   cpu_addr/cpu_wdata      CPU word address / write data
//   stall                   CPU must hold its request this cycle
//   hit                     cache tag match and valid for cpu_addr
//   cache_re/refill/update  cache read enable / line write / word write
//   tag/index/offset        cpu_addr split as [9:7] / [6:2] / [1:0]
//   line_data               assembled line; word k at [32k+31:32k]
//   write_data              cpu_wdata toward the cache
//   mem_req/mem_we          memory request (held until mem_ready) / direction
//   mem_addr/mem_wdata      memory word address / write data
//   mem_rdata/mem_ready     memory read data / transfer-done strobe
//   dbg_state               FSM state: 0=IDLE 1=FETCH 2=REFILL 3=WRITE
//
// Handshake: a memory transfer completes in a cycle where mem_req=1 and
// mem_ready=1. mem_req, mem_we and mem_addr stay stable until that cycle, and
// mem_ready is ignored whenever mem_req=0.
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int  LINE_W = 128,
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 10,
    parameter int  WORDS  = 4,
    localparam int OFF_W  = $clog2(WORDS),
    localparam int IDX_W  = 5,
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              stall,
    input  logic              hit,
    output logic              cache_re,
    output logic              refill,
    output logic              update,
    output logic [TAG_W-1:0]  tag,
    output logic [IDX_W-1:0]  index,
    output logic [OFF_W-1:0]  offset,
    output logic [LINE_W-1:0] line_data,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_REFILL = 2'd2,
        S_WRITE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic stall_c, cache_re_c, refill_c, update_c, mem_req_c, mem_we_c;

    assign tag        = cpu_addr[ADDR_W-1 -: TAG_W];
    assign index      = cpu_addr[OFF_W +: IDX_W];
    assign offset     = cpu_addr[OFF_W-1:0];
    assign write_data = cpu_wdata;
    assign mem_wdata  = cpu_wdata;
    assign line_data  = line_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        stall_c    = 1'b0;
        cache_re_c = 1'b0;
        refill_c   = 1'b0;
        update_c   = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr   = cpu_addr;
        case (state_q)
            S_IDLE: begin
                // A write wins over a simultaneous read request.
                if (cpu_we) begin
                    stall_c = 1'b1;
                    state_d = S_WRITE;
                end else if (cpu_re) begin
                    if (hit) begin
                        cache_re_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                stall_c   = 1'b1;
                mem_req_c = 1'b1;
                // Line base from cpu_addr, word select from the counter.
                mem_addr  = {cpu_addr[ADDR_W-1:OFF_W], cnt_q};
                if (mem_ready) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (cnt_q == OFF_W'(k)) begin
                            line_d[k*DATA_W +: DATA_W] = mem_rdata;
                        end
                    end
                    // The counter wraps to 0 on the last word.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS-1)) begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                refill_c = 1'b1;
                stall_c  = 1'b1;
                state_d  = S_IDLE;
            end
            S_WRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                // The CPU is released in the cycle memory accepts the write.
                stall_c   = !mem_ready;
                if (mem_ready) begin
                    update_c = hit;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with reset_n forces the control outputs low for as long as reset
    // is asserted, which also aborts any memory transfer immediately.
    assign stall    = reset_n & stall_c;
    assign cache_re = reset_n & cache_re_c;
    assign refill   = reset_n & refill_c;
    assign update   = reset_n & update_c;
    assign mem_req  = reset_n & mem_req_c;
    assign mem_we   = reset_n & mem_we_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

endmodule
